// File: rtl/spart_pkg.sv
// Shared SPART definitions: receiver state encoding and default frame geometry.
package spart_pkg;

  localparam int unsigned OVERSAMPLE_DEF = 16;
  localparam int unsigned DATA_BITS_DEF  = 8;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

endpackage

// File: rtl/spart_sync.sv
// Multi-flop 1-bit synchroniser for asynchronous inputs, with selectable reset level.
module spart_sync #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RESET_VAL   = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_q;

  // Shift the asynchronous input through the flop chain every clock.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_q <= {SYNC_STAGES{RESET_VAL}};
    else          sync_q <= {sync_q[SYNC_STAGES-2:0], d};
  end

  assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/spart_receiver.sv
// SPART receive half: oversampled 8N1 deserialiser with RDA, framing and overrun flags.
module spart_receiver
  import spart_pkg::*;
#(
  parameter int unsigned OVERSAMPLE  = OVERSAMPLE_DEF,
  parameter int unsigned DATA_BITS   = DATA_BITS_DEF,
  parameter bit          LSB_FIRST   = 1'b1,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 baud_en,
  input  logic                 RxD,
  input  logic                 rda_clear,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 RDA,
  output logic                 framing_err,
  output logic                 overrun_err
);

  localparam int unsigned TW = $clog2(OVERSAMPLE);
  localparam int unsigned BW = $clog2(DATA_BITS + 1);
  // Start detection already consumed one tick, so mid start bit is OVERSAMPLE/2-1 ticks later.
  localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLE / 2 - 2);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  logic                 rxs;
  rx_state_t            state_q, state_d;
  logic [TW-1:0]        tick_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shift_q;
  logic                 brk_wait;
  logic                 tick_clr, tick_inc, bit_clr, shift_en, done;

  spart_sync #(
    .SYNC_STAGES (SYNC_STAGES),
    .RESET_VAL   (1'b1)
  ) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (RxD),
    .q       (rxs)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= RX_IDLE;
    else          state_q <= state_d;
  end

  // Next-state and per-tick control strobes; nothing moves without baud_en.
  always_comb begin
    state_d  = state_q;
    tick_clr = 1'b0;
    tick_inc = 1'b0;
    bit_clr  = 1'b0;
    shift_en = 1'b0;
    done     = 1'b0;
    if (baud_en) begin
      unique case (state_q)
        RX_IDLE: begin
          if (!rxs && !brk_wait) begin
            state_d  = RX_START;
            tick_clr = 1'b1;
          end
        end
        RX_START: begin
          if (tick_cnt == TICK_HALF) begin
            tick_clr = 1'b1;
            bit_clr  = 1'b1;
            state_d  = rxs ? RX_IDLE : RX_DATA;
          end else begin
            tick_inc = 1'b1;
          end
        end
        RX_DATA: begin
          if (tick_cnt == TICK_LAST) begin
            tick_clr = 1'b1;
            shift_en = 1'b1;
            if (bit_cnt == BIT_LAST) state_d = RX_STOP;
          end else begin
            tick_inc = 1'b1;
          end
        end
        RX_STOP: begin
          if (tick_cnt == TICK_LAST) begin
            tick_clr = 1'b1;
            done     = 1'b1;
            state_d  = RX_IDLE;
          end else begin
            tick_inc = 1'b1;
          end
        end
        default: state_d = RX_IDLE;
      endcase
    end
  end

  // Tick/bit counters, shift register and the break re-arm guard.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shift_q  <= '0;
      brk_wait <= 1'b0;
    end else begin
      if (tick_clr)      tick_cnt <= '0;
      else if (tick_inc) tick_cnt <= tick_cnt + 1'b1;

      if (bit_clr)       bit_cnt <= '0;
      else if (shift_en) bit_cnt <= bit_cnt + 1'b1;

      if (shift_en) begin
        if (LSB_FIRST) shift_q <= {rxs, shift_q[DATA_BITS-1:1]};
        else           shift_q <= {shift_q[DATA_BITS-2:0], rxs};
      end

      // A low stop bit blocks new starts until the line has been seen high again.
      if (done)                                       brk_wait <= ~rxs;
      else if (state_q == RX_IDLE && baud_en && rxs)  brk_wait <= 1'b0;
    end
  end

  // Output byte and status flags; frame completion takes priority over rda_clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_data     <= '0;
      RDA         <= 1'b0;
      framing_err <= 1'b0;
      overrun_err <= 1'b0;
    end else if (done) begin
      rx_data     <= shift_q;
      RDA         <= 1'b1;
      framing_err <= ~rxs;
      overrun_err <= ~rda_clear & (overrun_err | RDA);
    end else if (rda_clear) begin
      RDA         <= 1'b0;
      framing_err <= 1'b0;
      overrun_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spart_receiver.sv
// Self-checking bench for spart_receiver: directed table, hand-timed corner cases, random frames.
module tb_spart_receiver;

  logic       clk = 1'b0;
  logic       reset_n, baud_en, RxD, rda_clear;
  logic [7:0] rx_data, rx_data_m;
  logic       RDA, fe, oe, RDA_m, fe_m, oe_m;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int          bcnt = 0;
  int          lat = 609;
  int          rda_rises = 0;
  logic        rda_prev = 1'b0;
  logic [7:0]  last_data;

  // Behavioural model state (frame-level view of the receiver).
  logic [7:0] m_data;
  bit         m_rda, m_fe, m_oe;

  typedef struct {
    logic [7:0] data;
    bit         stop;
    int         per;
    bit         clr_before;
    bit         clr_after;
    logic [7:0] exp_data;
    bit         exp_rda;
    bit         exp_fe;
    bit         exp_oe;
    logic [7:0] exp_msb;
  } vec_t;
  vec_t vecs[8];

  always #5 clk = ~clk;

  spart_receiver #(.OVERSAMPLE(16), .DATA_BITS(8), .LSB_FIRST(1'b1), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset_n(reset_n), .baud_en(baud_en), .RxD(RxD), .rda_clear(rda_clear),
    .rx_data(rx_data), .RDA(RDA), .framing_err(fe), .overrun_err(oe)
  );

  spart_receiver #(.OVERSAMPLE(16), .DATA_BITS(8), .LSB_FIRST(1'b0), .SYNC_STAGES(2)) dut_msb (
    .clk(clk), .reset_n(reset_n), .baud_en(baud_en), .RxD(RxD), .rda_clear(rda_clear),
    .rx_data(rx_data_m), .RDA(RDA_m), .framing_err(fe_m), .overrun_err(oe_m)
  );

  // Free-running 16x baud enable: one clk in four.
  initial begin
    baud_en = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bcnt    = (bcnt + 1) % 4;
      baud_en = (bcnt == 0);
    end
  end

  // Count RDA rising edges.
  initial forever begin
    @(negedge clk);
    if (RDA && !rda_prev) rda_rises++;
    rda_prev = RDA;
  end

  initial begin
    #3ms;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [7:0] ed, input bit erda,
                           input bit efe, input bit eoe, input logic [7:0] edm);
    @(negedge clk);
    check({tag, ".rx_data"}, rx_data, ed);
    check({tag, ".RDA"}, RDA, erda);
    check({tag, ".framing_err"}, fe, efe);
    check({tag, ".overrun_err"}, oe, eoe);
    check({tag, ".rx_data_msb"}, rx_data_m, edm);
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic align();
    do step(); while (!baud_en);
  endtask

  task automatic idle_bits(input int n);
    RxD = 1'b1;
    repeat (n * 64) step();
  endtask

  task automatic do_clear();
    rda_clear = 1'b1;
    step();
    rda_clear = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] d, input bit stop, input int per);
    RxD = 1'b0;
    repeat (per) step();
    for (int i = 0; i < 8; i++) begin
      RxD = d[i];
      repeat (per) step();
    end
    RxD = stop;
    repeat (per) step();
    RxD = 1'b1;
  endtask

  task automatic model_clear();
    m_rda = 1'b0;
    m_fe  = 1'b0;
    m_oe  = 1'b0;
  endtask

  task automatic model_frame(input logic [7:0] d, input bit stop);
    m_oe   = m_oe | m_rda;
    m_data = d;
    m_rda  = 1'b1;
    m_fe   = !stop;
  endtask

  initial begin
    bit found;
    int per_tab[3];
    per_tab = '{62, 64, 66};

    vecs[0] = '{8'h3C, 1'b0, 64, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b1, 1'b0, 8'h3C};
    vecs[1] = '{8'h00, 1'b1, 62, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00};
    vecs[2] = '{8'hFF, 1'b1, 66, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0, 8'hFF};
    vecs[3] = '{8'h55, 1'b1, 62, 1'b0, 1'b0, 8'h55, 1'b1, 1'b0, 1'b1, 8'hAA};
    vecs[4] = '{8'h01, 1'b1, 66, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0, 1'b0, 8'h80};
    vecs[5] = '{8'h55, 1'b1, 66, 1'b0, 1'b1, 8'h55, 1'b1, 1'b0, 1'b1, 8'hAA};
    vecs[6] = '{8'h00, 1'b1, 66, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00};
    vecs[7] = '{8'hFF, 1'b1, 62, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0, 8'hFF};

    reset_n   = 1'b0;
    RxD       = 1'b1;
    rda_clear = 1'b0;
    repeat (5) step();
    check_out("reset", 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
    reset_n = 1'b1;
    idle_bits(1);

    // Single frame; also measures start-edge to RDA latency in clks.
    rda_rises = 0;
    found     = 1'b0;
    align();
    fork
      send_frame(8'hA5, 1'b1, 64);
      begin
        for (int n = 1; n <= 2000 && !found; n++) begin
          step();
          if (RDA) begin
            found = 1'b1;
            lat   = n;
          end
        end
      end
    join
    check("latency_seen", found, 1'b1);
    check("latency_range", (lat >= 600 && lat <= 620), 1'b1);
    idle_bits(1);
    check_out("single", 8'hA5, 1'b1, 1'b0, 1'b0, 8'hA5);
    check("single.rda_rises", rda_rises, 1);

    // Directed table.
    for (int i = 0; i < 8; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      if (vecs[i].clr_before) do_clear();
      send_frame(vecs[i].data, vecs[i].stop, vecs[i].per);
      check_out(tag, vecs[i].exp_data, vecs[i].exp_rda, vecs[i].exp_fe, vecs[i].exp_oe, vecs[i].exp_msb);
      if (vecs[i].clr_after) begin
        do_clear();
        check_out({tag, "_clr"}, vecs[i].exp_data, 1'b0, 1'b0, 1'b0, vecs[i].exp_msb);
      end
      last_data = vecs[i].exp_data;
      idle_bits(1);
    end

    // Glitch: 5 baud ticks low must be rejected.
    do_clear();
    idle_bits(1);
    RxD = 1'b0;
    repeat (20) step();
    RxD = 1'b1;
    idle_bits(2);
    check_out("glitch", last_data, 1'b0, 1'b0, 1'b0, rev8(last_data));
    send_frame(8'hC3, 1'b1, 64);
    check_out("after_glitch", 8'hC3, 1'b1, 1'b0, 1'b0, 8'hC3);

    // Overrun: back-to-back frames without clearing.
    do_clear();
    idle_bits(1);
    send_frame(8'h11, 1'b1, 64);
    send_frame(8'h22, 1'b1, 64);
    check_out("overrun", 8'h22, 1'b1, 1'b0, 1'b1, 8'h44);

    // Overrun with rda_clear landing on the completion clk of the second frame.
    do_clear();
    idle_bits(1);
    align();
    fork
      begin
        send_frame(8'h11, 1'b1, 64);
        send_frame(8'h22, 1'b1, 64);
      end
      begin
        repeat (640 + lat - 1) step();
        rda_clear = 1'b1;
        step();
        rda_clear = 1'b0;
      end
    join
    check_out("overrun_clr", 8'h22, 1'b1, 1'b0, 1'b0, 8'h44);

    // Reset during data bit 4 of 0xFF, then a clean 0x5A.
    idle_bits(1);
    fork
      send_frame(8'hFF, 1'b1, 64);
      begin
        repeat (5 * 64 + 32) step();
        reset_n = 1'b0;
        check_out("in_reset", 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
        repeat (5) step();
        reset_n = 1'b1;
      end
    join
    idle_bits(2);
    check_out("post_reset_idle", 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
    send_frame(8'h5A, 1'b1, 64);
    check_out("post_reset", 8'h5A, 1'b1, 1'b0, 1'b0, 8'h5A);

    // Break: line held low gives 0 with framing error, no rearm while low.
    do_clear();
    RxD = 1'b0;
    repeat (12 * 64) step();
    check_out("break", 8'h00, 1'b1, 1'b1, 1'b0, 8'h00);
    do_clear();
    repeat (12 * 64) step();
    check_out("break_hold", 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
    idle_bits(2);
    send_frame(8'h96, 1'b1, 64);
    check_out("after_break", 8'h96, 1'b1, 1'b0, 1'b0, 8'h69);

    // Random frames against the frame-level model.
    idle_bits(1);
    do_clear();
    model_clear();
    m_data = 8'h96;
    for (int i = 0; i < 24; i++) begin
      logic [7:0] d;
      bit         stop;
      int         per;
      d    = 8'($urandom);
      stop = ($urandom_range(0, 4) != 0);
      per  = per_tab[$urandom_range(0, 2)];
      if ($urandom_range(0, 1) == 1) begin
        do_clear();
        model_clear();
      end
      send_frame(d, stop, per);
      model_frame(d, stop);
      check_out($sformatf("rand%0d", i), m_data, m_rda, m_fe, m_oe, rev8(m_data));
      idle_bits(1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
